// File: rtl/tile_mem_arbiter_pkg.sv
// Shared definitions for the tile-grid RAM arbiter.
// Holds the grid geometry, tile codes, the arbiter FSM state type and
// a range-check helper used by every path that turns an address into a
// RAM command.
package tile_mem_arbiter_pkg;

  localparam int COLS   = 40;
  localparam int ROWS   = 30;
  localparam int DEPTH  = COLS * ROWS;
  localparam int ADDR_W = 11;
  localparam int TILE_W = 2;

  typedef logic [TILE_W-1:0] tile_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam tile_t TILE_EMPTY = 2'd0;
  localparam tile_t TILE_BODY  = 2'd1;
  localparam tile_t TILE_HEAD  = 2'd2;
  localparam tile_t TILE_FOOD  = 2'd3;
  localparam tile_t CLEAR_TILE = TILE_EMPTY;

  // First invalid address and last valid address of the grid.
  localparam addr_t DEPTH_A = ADDR_W'(DEPTH);
  localparam addr_t LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

  // Addresses at or above DEPTH never reach the RAM.
  function automatic logic addr_in_range(input addr_t a);
    return (a < DEPTH_A);
  endfunction

endpackage

// File: rtl/tile_mem_arbiter_if.sv
// Bus bundle between the arbiter and its users.
// Carries the display fetch port, the game request/ack port, the clear
// control port and the RAM command/read-data port.
//   slave  : arbiter side (tile_mem_arbiter)
//   master : environment side (fetcher, game engine, RAM)
interface tile_mem_arbiter_if;
  import tile_mem_arbiter_pkg::*;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [TILE_W-1:0] disp_data;

  logic              game_req;
  logic              game_we;
  logic [ADDR_W-1:0] game_addr;
  logic [TILE_W-1:0] game_wdata;
  logic              game_ack;
  logic [TILE_W-1:0] game_rdata;

  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [TILE_W-1:0] ram_wdata;
  logic [TILE_W-1:0] ram_rdata;

  modport slave (
    input  disp_req, disp_addr, game_req, game_we, game_addr, game_wdata,
           clr_start, ram_rdata,
    output disp_valid, disp_data, game_ack, game_rdata, clr_busy, clr_done,
           ram_addr, ram_we, ram_wdata
  );

  modport master (
    output disp_req, disp_addr, game_req, game_we, game_addr, game_wdata,
           clr_start, ram_rdata,
    input  disp_valid, disp_data, game_ack, game_rdata, clr_busy, clr_done,
           ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/tile_mem_arbiter_clear_seq.sv
// Full-grid clear sequencer (module tile_clear_seq).
// Walks a counter from 0 to DEPTH-1, writing one entry on every cycle the
// RAM port is free, then returns to IDLE and pulses done.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   start_i        : start pulse, ignored while clearing
//   free_i         : RAM port available to the clear this cycle
//   busy_o         : FSM is in CLEAR
//   done_o         : one-cycle pulse after the last entry is written
//   wr_o, addr_o   : write request and its address for this cycle
module tile_clear_seq
  import tile_mem_arbiter_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              free_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              wr_o,
  output logic [ADDR_W-1:0] addr_o
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              wr_s;

  assign busy_o = (state_q == CLEAR);
  assign wr_s   = (state_q == CLEAR) & free_i;
  assign wr_o   = wr_s;
  assign addr_o = cnt_q;
  assign done_o = done_q;

  // State, counter and done-pulse registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= {ADDR_W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: the counter only advances on cycles a write went out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CLEAR;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (wr_s) begin
          if (cnt_q == LAST_A) begin
            state_d = IDLE;
            cnt_d   = {ADDR_W{1'b0}};
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/tile_mem_arbiter.sv
// Tile-grid RAM arbiter: owns every command to the single-port grid RAM.
// Priority each cycle is display > clear > game; at most one command.
// Ports:
//   clk, rst_n : 100 MHz clock, asynchronous active-low reset
//   bus        : slave side of tile_mem_arbiter_if (display fetch, game
//                request/ack, clear control, RAM command and read data)
// Display reads return data two cycles after the request; game writes ack
// one cycle after grant, game reads two cycles after grant.
module tile_mem_arbiter
  import tile_mem_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  tile_mem_arbiter_if.slave  bus
);

  logic              clr_busy_s, clr_done_s, clr_wr_s;
  logic [ADDR_W-1:0] clr_addr_s;

  logic              disp_inr_s, game_inr_s, game_pend_s, game_grant_s;
  logic              cmd_we_s;
  logic [ADDR_W-1:0] cmd_addr_s;
  logic [TILE_W-1:0] cmd_wdata_s;

  logic [ADDR_W-1:0] last_addr_q;
  logic [TILE_W-1:0] last_wdata_q;
  logic              disp_p1_q, disp_p1_d;
  logic              disp_inr_p1_q, disp_inr_p1_d;
  logic              disp_valid_q, disp_valid_d;
  logic [TILE_W-1:0] disp_data_q, disp_data_d;
  logic              rd_p1_q, rd_p1_d;
  logic              rd_inr_p1_q, rd_inr_p1_d;
  logic              game_ack_q, game_ack_d;
  logic [TILE_W-1:0] game_rdata_q, game_rdata_d;

  // The clear only gets the port on cycles without a display request.
  tile_clear_seq u_clear_seq (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (bus.clr_start),
    .free_i  (~bus.disp_req),
    .busy_o  (clr_busy_s),
    .done_o  (clr_done_s),
    .wr_o    (clr_wr_s),
    .addr_o  (clr_addr_s)
  );

  assign disp_inr_s = addr_in_range(bus.disp_addr);
  assign game_inr_s = addr_in_range(bus.game_addr);

  // A transaction stays pending through its ack cycle, which spaces
  // write grants 2 cycles apart and read grants 3 apart.
  assign game_pend_s  = rd_p1_q | game_ack_q;
  assign game_grant_s = bus.game_req & ~game_pend_s & ~bus.disp_req & ~clr_busy_s;

  // RAM command mux; address and write data hold their last value when idle.
  always_comb begin
    cmd_we_s    = 1'b0;
    cmd_addr_s  = last_addr_q;
    cmd_wdata_s = last_wdata_q;
    if (bus.disp_req) begin
      if (disp_inr_s) begin
        cmd_addr_s = bus.disp_addr;
      end else begin
        cmd_addr_s = last_addr_q;
      end
    end else if (clr_wr_s) begin
      cmd_we_s    = 1'b1;
      cmd_addr_s  = clr_addr_s;
      cmd_wdata_s = CLEAR_TILE;
    end else if (game_grant_s && game_inr_s) begin
      cmd_addr_s = bus.game_addr;
      if (bus.game_we) begin
        cmd_we_s    = 1'b1;
        cmd_wdata_s = bus.game_wdata;
      end else begin
        cmd_we_s = 1'b0;
      end
    end else begin
      cmd_we_s = 1'b0;
    end
  end

  assign bus.ram_we    = cmd_we_s;
  assign bus.ram_addr  = cmd_addr_s;
  assign bus.ram_wdata = cmd_wdata_s;

  // Display and game return pipelines; out-of-range accesses return empty.
  always_comb begin
    disp_p1_d     = bus.disp_req;
    disp_inr_p1_d = disp_inr_s;
    disp_valid_d  = disp_p1_q;
    if (disp_p1_q) begin
      disp_data_d = disp_inr_p1_q ? bus.ram_rdata : TILE_EMPTY;
    end else begin
      disp_data_d = disp_data_q;
    end
    rd_p1_d     = game_grant_s & ~bus.game_we;
    rd_inr_p1_d = game_inr_s;
    game_ack_d  = (game_grant_s & bus.game_we) | rd_p1_q;
    if (rd_p1_q) begin
      game_rdata_d = rd_inr_p1_q ? bus.ram_rdata : TILE_EMPTY;
    end else begin
      game_rdata_d = game_rdata_q;
    end
  end

  // Pipeline and hold registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr_q   <= {ADDR_W{1'b0}};
      last_wdata_q  <= TILE_EMPTY;
      disp_p1_q     <= 1'b0;
      disp_inr_p1_q <= 1'b0;
      disp_valid_q  <= 1'b0;
      disp_data_q   <= TILE_EMPTY;
      rd_p1_q       <= 1'b0;
      rd_inr_p1_q   <= 1'b0;
      game_ack_q    <= 1'b0;
      game_rdata_q  <= TILE_EMPTY;
    end else begin
      last_addr_q   <= cmd_addr_s;
      last_wdata_q  <= cmd_wdata_s;
      disp_p1_q     <= disp_p1_d;
      disp_inr_p1_q <= disp_inr_p1_d;
      disp_valid_q  <= disp_valid_d;
      disp_data_q   <= disp_data_d;
      rd_p1_q       <= rd_p1_d;
      rd_inr_p1_q   <= rd_inr_p1_d;
      game_ack_q    <= game_ack_d;
      game_rdata_q  <= game_rdata_d;
    end
  end

  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.game_ack   = game_ack_q;
  assign bus.game_rdata = game_rdata_q;
  assign bus.clr_busy   = clr_busy_s;
  assign bus.clr_done   = clr_done_s;

endmodule

// File: tb/tb_tile_mem_arbiter.sv
// Testbench for tile_mem_arbiter: behavioural RAM, a cycle model built from
// the arbitration rules (scheduled expectations per future cycle), random
// traffic and directed scenarios with literal expectations.
module tb_tile_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tile_mem_arbiter_if bus();
  tile_mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Grid RAM with one-cycle synchronous read.
  logic [1:0] ram [0:2047];
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0] mm [0:2047];
  bit        e_dv [4];
  bit        e_ga [4];
  bit        e_gr [4];
  bit        e_dn [4];
  logic [1:0] e_dd [4];
  logic [1:0] e_grd [4];
  bit        m_clr = 1'b0;
  int        m_cnt = 0;
  int        m_free = 0;
  int        cyc = 0;
  logic [10:0] m_addr = 11'd0;
  logic [1:0]  m_wd = 2'd0;

  always @(negedge clk) begin : model
    int s, n1, n2;
    bit clr_now, ewe;
    logic [10:0] ea;
    logic [1:0] ewd;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        e_dv[k] = 1'b0; e_ga[k] = 1'b0; e_gr[k] = 1'b0; e_dn[k] = 1'b0;
      end
      m_clr = 1'b0; m_cnt = 0; m_free = 0; m_addr = 11'd0; m_wd = 2'd0;
    end else begin
      s = cyc % 4; n1 = (cyc + 1) % 4; n2 = (cyc + 2) % 4;
      chk("disp_valid", int'(bus.disp_valid), int'(e_dv[s]));
      if (e_dv[s]) chk("disp_data", int'(bus.disp_data), int'(e_dd[s]));
      chk("game_ack", int'(bus.game_ack), int'(e_ga[s]));
      if (e_gr[s]) chk("game_rdata", int'(bus.game_rdata), int'(e_grd[s]));
      chk("clr_done", int'(bus.clr_done), int'(e_dn[s]));
      chk("clr_busy", int'(bus.clr_busy), int'(m_clr));
      e_dv[s] = 1'b0; e_ga[s] = 1'b0; e_gr[s] = 1'b0; e_dn[s] = 1'b0;

      clr_now = m_clr; ewe = 1'b0; ea = m_addr; ewd = m_wd;
      if (bus.disp_req) begin
        e_dv[n2] = 1'b1;
        if (bus.disp_addr < 11'd1200) begin
          ea = bus.disp_addr;
          e_dd[n2] = mm[ea];
        end else begin
          e_dd[n2] = 2'd0;
        end
      end else if (clr_now) begin
        ewe = 1'b1; ea = m_cnt[10:0]; ewd = 2'd0;
        m_cnt++;
        if (m_cnt == 1200) begin
          m_clr = 1'b0;
          e_dn[n1] = 1'b1;
        end
      end else if (bus.game_req && cyc >= m_free) begin
        if (bus.game_we) begin
          e_ga[n1] = 1'b1; m_free = cyc + 2;
          if (bus.game_addr < 11'd1200) begin
            ewe = 1'b1; ea = bus.game_addr; ewd = bus.game_wdata;
          end
        end else begin
          e_ga[n2] = 1'b1; e_gr[n2] = 1'b1; m_free = cyc + 3;
          if (bus.game_addr < 11'd1200) begin
            ea = bus.game_addr;
            e_grd[n2] = mm[ea];
          end else begin
            e_grd[n2] = 2'd0;
          end
        end
      end
      if (!clr_now && bus.clr_start) begin
        m_clr = 1'b1; m_cnt = 0;
      end
      chk("ram_we", int'(bus.ram_we), int'(ewe));
      chk("ram_addr", int'(bus.ram_addr), int'(ea));
      chk("ram_wdata", int'(bus.ram_wdata), int'(ewd));
      if (ewe) mm[ea] = ewd;
      m_addr = ea; m_wd = ewd;
      cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_disp_valid"}, int'(bus.disp_valid), 0);
    chk({tag, "_disp_data"}, int'(bus.disp_data), 0);
    chk({tag, "_game_ack"}, int'(bus.game_ack), 0);
    chk({tag, "_game_rdata"}, int'(bus.game_rdata), 0);
    chk({tag, "_clr_busy"}, int'(bus.clr_busy), 0);
    chk({tag, "_clr_done"}, int'(bus.clr_done), 0);
    chk({tag, "_ram_we"}, int'(bus.ram_we), 0);
    chk({tag, "_ram_addr"}, int'(bus.ram_addr), 0);
    chk({tag, "_ram_wdata"}, int'(bus.ram_wdata), 0);
  endtask

  // One game transaction with no competing traffic. lat counts samples from
  // the request cycle (1 = grant cycle) to the ack; 0 means no ack seen.
  task automatic game_op(input bit we, input int addr, input int wd,
                         output int lat, output int rd, output int we0, output int addr0);
    tick();
    bus.game_req = 1'b1; bus.game_we = we;
    bus.game_addr = 11'(addr); bus.game_wdata = 2'(wd);
    lat = 0; rd = 0; we0 = 0; addr0 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin we0 = int'(bus.ram_we); addr0 = int'(bus.ram_addr); end
      if (bus.game_ack) begin lat = i; rd = int'(bus.game_rdata); break; end
      tick();
    end
    tick();
    bus.game_req = 1'b0;
  endtask

  // Start a clear, optionally with display every 'period' cycles and a game
  // read held from the first clearing cycle; runs until done and game idle.
  task automatic run_clear(input int period, input bit with_game,
                           output int busy, output int blocked, output int dones, output int gack_busy);
    int post;
    bit drop;
    busy = 0; blocked = 0; dones = 0; gack_busy = 0; post = 0; drop = 1'b0;
    tick();
    bus.clr_start = 1'b1;
    @(negedge clk);
    tick();
    bus.clr_start = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (i == 0 && with_game) begin
        bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 11'd10;
      end
      if (drop) begin bus.game_req = 1'b0; drop = 1'b0; end
      bus.disp_req = (period > 0) && (i % period == 0);
      bus.disp_addr = 11'($urandom_range(0, 1199));
      @(negedge clk);
      if (bus.clr_busy) begin
        busy++;
        if (bus.disp_req) blocked++;
        if (bus.game_ack) gack_busy++;
      end
      if (bus.game_ack) drop = 1'b1;
      if (bus.clr_done) dones++;
      if (dones > 0) post++;
      if (post > 8 && !bus.game_req) break;
      tick();
    end
    tick();
    bus.disp_req = 1'b0;
    bus.game_req = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int lat, rd, we0, a0, busy, blocked, dones, gab;
    bit holding, ack_seen, found;
    bus.disp_req = 1'b0; bus.disp_addr = 11'd0;
    bus.game_req = 1'b0; bus.game_we = 1'b0; bus.game_addr = 11'd0; bus.game_wdata = 2'd0;
    bus.clr_start = 1'b0;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;

    // Write 3 to addr 5, read it back.
    game_op(1'b1, 5, 3, lat, rd, we0, a0);
    chk("wr5_we_at_grant", we0, 1);
    chk("wr5_addr_at_grant", a0, 5);
    chk("wr5_ack_latency", lat, 2);
    game_op(1'b0, 5, 0, lat, rd, we0, a0);
    chk("rd5_ack_latency", lat, 3);
    chk("rd5_rdata", rd, 3);

    // Clear with no traffic.
    run_clear(0, 1'b0, busy, blocked, dones, gab);
    chk("clr_idle_busy_cycles", busy, 1200);
    chk("clr_idle_done_pulses", dones, 1);

    // Display every cycle on 0..7 while a game read of addr 2 is held.
    game_op(1'b1, 1, 1, lat, rd, we0, a0);
    game_op(1'b1, 2, 2, lat, rd, we0, a0);
    game_op(1'b1, 3, 3, lat, rd, we0, a0);
    tick();
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 11'd2;
    for (int k = 0; k < 8; k++) begin
      bus.disp_req = 1'b1; bus.disp_addr = 11'(k);
      @(negedge clk);
      chk("ack_held_off_by_disp", int'(bus.game_ack), 0);
      tick();
    end
    bus.disp_req = 1'b0;
    lat = 0; rd = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.game_ack) begin lat = i; rd = int'(bus.game_rdata); break; end
      tick();
    end
    chk("ack_after_disp_drop", lat, 3);
    chk("rdata_after_disp_drop", rd, 2);
    tick();
    bus.game_req = 1'b0;

    // Clear with display every 4th cycle and a waiting game read.
    run_clear(4, 1'b1, busy, blocked, dones, gab);
    chk("clr_disp_busy_cycles", busy, 1200 + blocked);
    chk("clr_disp_done_pulses", dones, 1);
    chk("clr_disp_no_game_ack", gab, 0);

    // Out-of-range game accesses.
    game_op(1'b1, 1200, 3, lat, rd, we0, a0);
    chk("oor_wr_ack_latency", lat, 2);
    chk("oor_wr_no_we", we0, 0);
    game_op(1'b0, 2047, 0, lat, rd, we0, a0);
    chk("oor_rd_ack_latency", lat, 3);
    chk("oor_rd_rdata", rd, 0);
    chk("oor_rd_no_we", we0, 0);

    // Random traffic.
    holding = 1'b0; ack_seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (holding && ack_seen) begin
        bus.game_req = 1'b0; holding = 1'b0;
      end else if (!holding && $urandom_range(0, 2) == 0) begin
        bus.game_req = 1'b1;
        bus.game_we = 1'($urandom_range(0, 1));
        bus.game_addr = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(1200, 2047))
                                                    : 11'($urandom_range(0, 1199));
        bus.game_wdata = 2'($urandom_range(0, 3));
        holding = 1'b1;
      end
      bus.disp_req = ($urandom_range(0, 3) == 0);
      bus.disp_addr = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(1200, 2047))
                                                  : 11'($urandom_range(0, 1199));
      bus.clr_start = ($urandom_range(0, 499) == 0);
      @(negedge clk);
      ack_seen = bus.game_ack;
    end
    tick();
    bus.disp_req = 1'b0; bus.clr_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (holding && ack_seen) begin bus.game_req = 1'b0; holding = 1'b0; end
      @(negedge clk);
      ack_seen = bus.game_ack;
      if (!holding && !bus.clr_busy && !bus.game_ack) begin found = 1'b1; break; end
      tick();
    end
    chk("random_drain", int'(found), 1);

    // Reset in the middle of a clear.
    game_op(1'b1, 700, 2, lat, rd, we0, a0);
    chk("wr700_ack_latency", lat, 2);
    tick();
    bus.clr_start = 1'b1;
    @(negedge clk);
    tick();
    bus.clr_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.ram_we && bus.ram_addr == 11'd599) begin found = 1'b1; break; end
      tick();
    end
    chk("clr_reached_599", int'(found), 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midclr_reset");
    repeat (3) @(negedge clk);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_no_done", int'(bus.clr_done), 0);
      chk("post_reset_not_busy", int'(bus.clr_busy), 0);
    end
    game_op(1'b0, 700, 0, lat, rd, we0, a0);
    chk("rd700_ack_latency", lat, 3);
    chk("rd700_kept_value", rd, 2);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tile_mem_arbiter.md
Name: tile_mem_arbiter

Overview:
Arbitrates the single-port tile-grid RAM between three users: the VGA pixel fetcher (display), the snake game engine (game), and an internal clear-board sequencer. The grid is 40x30 tiles of 16x16 px covering the 640x480 screen. The block sits between the 100 MHz game/VGA logic and the grid RAM, and owns every RAM command. Display is never stalled. Clear outranks game.

Parameters:
COLS, 40, tiles per row
ROWS, 30, tile rows
DEPTH, COLS*ROWS (1200), valid RAM entries
ADDR_W, 11, address width (2^ADDR_W >= DEPTH)
TILE_W, 2, tile code width (0 empty, 1 body, 2 head, 3 food)
CLEAR_TILE, 0, code written by the clear sequencer

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
disp_req  in  1  single-cycle display fetch request
disp_addr  in  ADDR_W  display fetch address
disp_valid  out  1  display data valid, exactly 2 cycles after disp_req
disp_data  out  TILE_W  display tile code
game_req  in  1  game request; held with its fields until game_ack
game_we  in  1  1 = write, 0 = read
game_addr  in  ADDR_W  game address
game_wdata  in  TILE_W  game write data
game_ack  out  1  one-cycle completion pulse
game_rdata  out  TILE_W  read data, valid with game_ack on reads
clr_start  in  1  pulse that starts a full-grid clear
clr_busy  out  1  high while clearing
clr_done  out  1  one-cycle pulse when the clear finishes
ram_addr  out  ADDR_W  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  TILE_W  RAM write data
ram_rdata  in  TILE_W  RAM read data, 1-cycle synchronous read latency

Behaviour:
- Reset: all outputs 0, FSM in IDLE, clear counter 0, no game transaction pending.
- Per-cycle priority: display > clear > game. Exactly one RAM command per cycle, or none.
- Display path:
  - A disp_req in cycle N drives ram_addr in N. ram_rdata is registered into disp_data in N+1.
  - disp_valid is asserted in N+2. The pipeline is fully pipelined, so back-to-back requests are supported.
  - If disp_addr >= DEPTH, no RAM command is issued and disp_data = 0, still with 2-cycle latency.
- FSM states:
  - IDLE: accepts game traffic. clr_start moves the FSM to CLEAR on the next cycle.
  - CLEAR: clr_busy = 1. The counter runs from 0 to DEPTH-1. Each cycle with no disp_req, the block writes CLEAR_TILE at the counter address and increments the counter. After writing DEPTH-1 it returns to IDLE and pulses clr_done in the following cycle.
  - clr_start during CLEAR is ignored.
- Game handshake:
  - A grant occurs in cycle G when game_req=1, no transaction is pending, no disp_req, and the FSM is in IDLE.
  - Write: the RAM write is issued in G and game_ack pulses in G+1.
  - Read: the RAM read is issued in G and game_ack is asserted in G+2 with game_rdata.
  - No new game grant while a transaction is pending. Consecutive grants are at least 2 cycles apart for writes and 3 for reads.
  - If game_addr >= DEPTH: a write is dropped but still acked at G+1; a read returns 0 at G+2.
- Simultaneous events:
  - clr_start in the same cycle as a game grant: the game transaction completes normally and CLEAR begins the next cycle.
  - A game transaction already granted is never aborted by a clear.
  - Game requests arriving during CLEAR wait until IDLE.
- Starvation: continuous disp_req starves both clear and game. This is permitted because the fetcher issues at most 1 request per 4 cycles.
- Reset asserted mid-operation: the clear aborts without clr_done, the pending game transaction is dropped without game_ack, and display data in flight is discarded.
- ram_we is 0 whenever no write is issued. ram_addr and ram_wdata hold their last value when idle.

Decomposition:
- Shared package holds:
  - tile code constants TILE_EMPTY, TILE_BODY, TILE_HEAD, TILE_FOOD;
  - COLS, ROWS, DEPTH, ADDR_W;
  - FSM state enum {IDLE, CLEAR}.
- One sub-module is natural: tile_clear_seq (counter, busy/done, issue-when-free input). The arbiter mux and the game/display pipelines stay in the top.

Test Plan:
- Reset, then a game write of 3 to addr 5 -> ram_we=1 and ram_addr=5 in G, game_ack at G+1. A later game read of addr 5 -> game_ack at G+2 with game_rdata=3.
- disp_req every cycle on addrs 0..7 while game_req is held -> disp_valid is continuous with correct data at +2, and game_ack stays 0 until disp_req drops.
- clr_start with no traffic -> clr_busy for 1200 cycles, every entry reads 0 afterwards, clr_done pulses once.
- clr_start with disp_req every 4th cycle -> clear takes 1200 + number of display-blocked cycles, display data is correct throughout, no game_ack during clr_busy.
- Game write to addr 1200 and read of addr 2047 -> ack at G+1 and G+2, rdata=0, ram_we never asserted.
- rst_n low at counter=600 during clear -> all outputs 0 asynchronously, no clr_done; after release, a game read of addr 700 returns its pre-clear value.
